ahb3lite_interconnect_master_port: RTL and testbench
====================================================

Name: ahb3lite_interconnect_master_port

Overview:
Upstream stage of the AHB3-Lite multi-layer switch. There is one instance per AHB master. Each instance decodes the master's address to one of SLAVES slave ports and holds the address phase while that port has not yet granted this master. It muxes data-phase responses back from the addressed slave port. It generates the per-slave can_switch hints and the per-slave HSEL requests that the slave-port arbiters consume.

Parameters:
HADDR_SIZE, 32, address bus width
HDATA_SIZE, 32, data bus width
MASTERS, 3, number of master ports (sizes priority)
SLAVES, 8, number of slave ports
MASTER_BITS, $clog2(MASTERS), priority width (derived; do not override)
SLAVE_BITS, $clog2(SLAVES), slave index width (derived)

Ports:
HRESETn  in  1  asynchronous active-low reset
HCLK  in  1  clock, rising edge
mst_priority  in  MASTER_BITS  static priority of this master, passed through
slvHADDRbase  in  SLAVES x HADDR_SIZE  per-slave base address
slvHADDRmask  in  SLAVES x HADDR_SIZE  per-slave address mask (0 = slave disabled)
HSEL, HADDR, HWDATA, HWRITE, HSIZE[3], HBURST[3], HPROT[4], HTRANS[2], HMASTLOCK, HREADY  in  AHB slave-side inputs from master
HRDATA  out  HDATA_SIZE  read data to master
HREADYOUT  out  1  ready to master
HRESP  out  1  response to master
slvHSEL  out  SLAVES  one-hot request to slave ports
slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST, slvHPROT, slvHTRANS, slvHMASTLOCK  out  address/control/data broadcast to all slave ports
slvHREADY  out  1  this port's HREADY, fed to the slave ports' mstHREADY
slvpriority  out  MASTER_BITS  equal to mst_priority
slvHRDATA  in  SLAVES x HDATA_SIZE  per-slave read data
slvHREADYOUT  in  SLAVES  per-slave ready (the slave port's mstHREADYOUT)
slvHRESP  in  SLAVES  per-slave response
can_switch  out  SLAVES  this master may be released by slave port s
granted  in  SLAVES  slave port s currently grants this master

Behaviour:
- Decode:
  - match[s] = ((HADDR ^ slvHADDRbase[s]) & slvHADDRmask[s]) == 0 and slvHADDRmask[s] != 0.
  - When several slaves match, the lowest index wins.
  - The address source is the held register while in WAIT, and the live bus otherwise.
- Active transfer = HSEL & HTRANS in {NONSEQ, SEQ}, sampled when HREADY=1.
- States: IDLE_OK, WAIT, ERR1, ERR2. Reset state is IDLE_OK.
- IDLE_OK:
  - Active transfer, no match -> ERR1.
  - Active transfer, matched slave s with granted[s] & slvHREADYOUT[s] -> transfer passes through combinationally; the data-phase slave index dp_slv <= s.
  - Otherwise (matched but not granted) -> latch HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK into the hold register and go to WAIT.
- WAIT:
  - Drive the held values on slv* and keep slvHSEL[s]=1.
  - HREADYOUT=0 once any prior data phase completes.
  - A held HTRANS=SEQ is presented as NONSEQ.
  - Leave to IDLE_OK when granted[s] & slvHREADYOUT[s]; set dp_slv <= s at that edge.
- ERR1: HREADYOUT=0, HRESP=1, next state ERR2.
- ERR2: HREADYOUT=1, HRESP=1, next state IDLE_OK. IDLE or BUSY transfers in ERR2 are ignored.
- Data phase:
  - HRDATA=slvHRDATA[dp_slv], HRESP=slvHRESP[dp_slv], HREADYOUT=slvHREADYOUT[dp_slv] whenever a data phase is outstanding (dp_valid).
  - With no data phase outstanding: HREADYOUT=1, HRESP=0.
  - dp_valid is set when an address phase is accepted and cleared when HREADYOUT=1 with no new accept.
- slvHWDATA = HWDATA, a direct pass-through.
- slvHREADY = HREADY, except 0 while in WAIT.
- can_switch[s] = 1 unless slave s is addressed with HMASTLOCK=1 or the next HTRANS is SEQ/BUSY (mid-burst).
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0 (dp_slv=0 with slv inputs don't-care), slvHSEL=0.
  - dp_valid=0, hold register cleared, can_switch all 1.
- Reset mid-WAIT or mid-ERR aborts immediately to IDLE_OK; no response is completed.
- HREADY=0 from the bus: the decoder does not sample, and the held state is kept.
- Simultaneous WAIT-exit and a new master transfer is impossible, because HREADYOUT=0 in WAIT.

Decomposition:
- ahb3lite_pkg (existing) supplies the HTRANS_IDLE/BUSY/NONSEQ/SEQ and HRESP_OKAY/ERROR constants.
- The state typedef stays local to the module.
- One sub-module, ahb3lite_interconnect_address_decoder: combinational match with lowest-index priority, outputting the one-hot select and a no-match flag.

Test Plan:
- Setup: SLAVES=2, base0=0x0000_0000/mask 0xF000_0000, base1=0x1000_0000/mask 0xF000_0000.
- NONSEQ to 0x1000_0004, granted[1]=1 -> slvHSEL=2'b10 the same cycle; next-cycle HRDATA = slvHRDATA[1]; HRESP=0.
- NONSEQ to 0x0000_0010, granted[0]=0 for 3 cycles -> HREADYOUT=0 for 3 cycles with held address/control on slv*; released the cycle after granted[0]=1.
- SEQ to 0x1000_0008 while not granted -> slvHTRANS=NONSEQ while held.
- NONSEQ to 0x2000_0000 (unmapped) -> HREADYOUT/HRESP = 0/1, then 1/1, then HREADYOUT=1, HRESP=0.
- INCR4 with HMASTLOCK=0 -> can_switch[1]=0 during beats 1-3 (next is SEQ), 1 after the final beat. Same sequence with HMASTLOCK=1 -> can_switch[1]=0 throughout.
- Assert HRESETn=0 during WAIT -> next cycle HREADYOUT=1, slvHSEL=0, state IDLE_OK.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings used across the interconnect.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb3lite_interconnect_master_port_if.sv
// AHB3-Lite bus between one master and its interconnect master port.
interface ahb3lite_interconnect_master_port_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
) ();
    logic                  HSEL;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic                  HREADY;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb3lite_interconnect_address_decoder.sv
// Base/mask address match; the lowest-indexed matching slave wins.
module ahb3lite_interconnect_address_decoder #(
    parameter int HADDR_SIZE = 32,
    parameter int SLAVES     = 8,
    parameter int SLAVE_BITS = $clog2(SLAVES)
) (
    input  logic [HADDR_SIZE-1:0]             addr,
    input  logic [SLAVES-1:0][HADDR_SIZE-1:0] base,
    input  logic [SLAVES-1:0][HADDR_SIZE-1:0] mask,
    output logic [SLAVES-1:0]                 sel,
    output logic [SLAVE_BITS-1:0]             sel_idx,
    output logic                              no_match
);
    logic [SLAVES-1:0] match;

    generate
        for (genvar gi = 0; gi < SLAVES; gi++) begin : g_match
            // an all-zero mask disables the slave
            assign match[gi] = ~|((addr ^ base[gi]) & mask[gi]) & |mask[gi];
        end
    endgenerate

    always_comb begin
        sel      = '0;
        sel_idx  = '0;
        no_match = 1'b1;
        for (int i = SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel      = '0;
                sel[i]   = 1'b1;
                sel_idx  = SLAVE_BITS'(i);
                no_match = 1'b0;
            end
        end
    end
endmodule

// File: rtl/ahb3lite_interconnect_master_port.sv
// Per-master front end of the multi-layer switch: decode, hold while ungranted, response mux.
module ahb3lite_interconnect_master_port
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MASTERS     = 3,
    parameter int SLAVES      = 8,
    parameter int MASTER_BITS = $clog2(MASTERS),
    parameter int SLAVE_BITS  = $clog2(SLAVES)
) (
    input  logic                              HRESETn,
    input  logic                              HCLK,
    input  logic [MASTER_BITS-1:0]            mst_priority,
    input  logic [SLAVES-1:0][HADDR_SIZE-1:0] slvHADDRbase,
    input  logic [SLAVES-1:0][HADDR_SIZE-1:0] slvHADDRmask,
    ahb3lite_interconnect_master_port_if.slave mst,
    output logic [SLAVES-1:0]                 slvHSEL,
    output logic [HADDR_SIZE-1:0]             slvHADDR,
    output logic [HDATA_SIZE-1:0]             slvHWDATA,
    output logic                              slvHWRITE,
    output logic [2:0]                        slvHSIZE,
    output logic [2:0]                        slvHBURST,
    output logic [3:0]                        slvHPROT,
    output logic [1:0]                        slvHTRANS,
    output logic                              slvHMASTLOCK,
    output logic                              slvHREADY,
    output logic [MASTER_BITS-1:0]            slvpriority,
    input  logic [SLAVES-1:0][HDATA_SIZE-1:0] slvHRDATA,
    input  logic [SLAVES-1:0]                 slvHREADYOUT,
    input  logic [SLAVES-1:0]                 slvHRESP,
    output logic [SLAVES-1:0]                 can_switch,
    input  logic [SLAVES-1:0]                 granted
);
    typedef enum logic [1:0] {IDLE_OK, WAIT, ERR1, ERR2} state_t;

    typedef struct packed {
        logic [HADDR_SIZE-1:0] addr;
        logic                  write;
        logic [2:0]            size;
        logic [2:0]            burst;
        logic [3:0]            prot;
        logic [1:0]            trans;
        logic                  lock;
    } hold_t;

    state_t                state_q, state_d;
    hold_t                 hold_q, hold_d, live, cur;
    logic                  dp_valid_q, dp_valid_d;
    logic [SLAVE_BITS-1:0] dp_slv_q, dp_slv_d;

    logic [SLAVES-1:0]     dec_sel;
    logic [SLAVE_BITS-1:0] dec_idx;
    logic                  dec_none;
    logic                  req, active, grant_ok, accept, in_wait, mid_burst;
    logic                  hready_out, hresp;
    logic [HDATA_SIZE-1:0] hrdata;

    always_comb begin
        live.addr  = mst.HADDR;
        live.write = mst.HWRITE;
        live.size  = mst.HSIZE;
        live.burst = mst.HBURST;
        live.prot  = mst.HPROT;
        live.trans = mst.HTRANS;
        live.lock  = mst.HMASTLOCK;
    end

    assign in_wait = (state_q == WAIT);
    assign cur     = in_wait ? hold_q : live;

    ahb3lite_interconnect_address_decoder #(
        .HADDR_SIZE (HADDR_SIZE),
        .SLAVES     (SLAVES),
        .SLAVE_BITS (SLAVE_BITS)
    ) u_decoder (
        .addr     (cur.addr),
        .base     (slvHADDRbase),
        .mask     (slvHADDRmask),
        .sel      (dec_sel),
        .sel_idx  (dec_idx),
        .no_match (dec_none)
    );

    assign req      = mst.HSEL & ((mst.HTRANS == HTRANS_NONSEQ) | (mst.HTRANS == HTRANS_SEQ));
    assign active   = req & mst.HREADY;
    assign grant_ok = |(dec_sel & granted & slvHREADYOUT);
    assign accept   = (((state_q == IDLE_OK) | (state_q == ERR2)) & active & grant_ok)
                    | (in_wait & grant_ok);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE_OK;
            hold_q     <= '0;
            dp_valid_q <= 1'b0;
            dp_slv_q   <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            dp_valid_q <= dp_valid_d;
            dp_slv_q   <= dp_slv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        dp_valid_d = dp_valid_q;
        dp_slv_d   = dp_slv_q;
        case (state_q)
            IDLE_OK, ERR2: begin
                state_d = IDLE_OK;
                if (active) begin
                    if (dec_none) begin
                        state_d = ERR1;
                    end else if (!grant_ok) begin
                        state_d = WAIT;
                        hold_d  = live;
                    end
                end
            end
            WAIT:    if (grant_ok) state_d = IDLE_OK;
            ERR1:    state_d = ERR2;
            default: state_d = IDLE_OK;
        endcase
        if (accept) begin
            dp_valid_d = 1'b1;
            dp_slv_d   = dec_idx;
        end else if (hready_out) begin
            dp_valid_d = 1'b0;
        end
    end

    always_comb begin
        slvHSEL    = '0;
        hready_out = 1'b1;
        hresp      = HRESP_OKAY;
        hrdata     = '0;
        if (dp_valid_q) begin
            hrdata     = slvHRDATA[dp_slv_q];
            hresp      = slvHRESP[dp_slv_q];
            hready_out = slvHREADYOUT[dp_slv_q];
        end
        case (state_q)
            WAIT: begin
                slvHSEL = dec_sel;
                if (!dp_valid_q) hready_out = 1'b0;
            end
            ERR1: begin
                hready_out = 1'b0;
                hresp      = HRESP_ERROR;
            end
            ERR2: begin
                hready_out = 1'b1;
                hresp      = HRESP_ERROR;
                if (req) slvHSEL = dec_sel;
            end
            default: if (req) slvHSEL = dec_sel;
        endcase
    end

    assign mst.HRDATA    = hrdata;
    assign mst.HREADYOUT = hready_out;
    assign mst.HRESP     = hresp;

    assign slvHADDR     = cur.addr;
    assign slvHWRITE    = cur.write;
    assign slvHSIZE     = cur.size;
    assign slvHBURST    = cur.burst;
    assign slvHPROT     = cur.prot;
    assign slvHMASTLOCK = cur.lock;
    // a held SEQ restarts as NONSEQ because the slave port never saw the burst start
    assign slvHTRANS    = (in_wait && hold_q.trans == HTRANS_SEQ) ? HTRANS_NONSEQ : cur.trans;
    assign slvHWDATA    = mst.HWDATA;
    assign slvHREADY    = in_wait ? 1'b0 : mst.HREADY;
    assign slvpriority  = mst_priority;

    assign mid_burst = (cur.trans == HTRANS_SEQ) | (cur.trans == HTRANS_BUSY);

    generate
        for (genvar gi = 0; gi < SLAVES; gi++) begin : g_can_switch
            assign can_switch[gi] = ~(dec_sel[gi] & (in_wait | mst.HSEL) & (cur.lock | mid_burst));
        end
    endgenerate
endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// Directed bench for the interconnect master port with two slave ports.
module tb_ahb3lite_interconnect_master_port;
    localparam int SLAVES = 2;

    logic                    HRESETn;
    logic                    HCLK;
    logic [1:0]              mst_priority;
    logic [SLAVES-1:0][31:0] slvHADDRbase;
    logic [SLAVES-1:0][31:0] slvHADDRmask;
    logic [SLAVES-1:0]       slvHSEL;
    logic [31:0]             slvHADDR;
    logic [31:0]             slvHWDATA;
    logic                    slvHWRITE;
    logic [2:0]              slvHSIZE;
    logic [2:0]              slvHBURST;
    logic [3:0]              slvHPROT;
    logic [1:0]              slvHTRANS;
    logic                    slvHMASTLOCK;
    logic                    slvHREADY;
    logic [1:0]              slvpriority;
    logic [SLAVES-1:0][31:0] slvHRDATA;
    logic [SLAVES-1:0]       slvHREADYOUT;
    logic [SLAVES-1:0]       slvHRESP;
    logic [SLAVES-1:0]       can_switch;
    logic [SLAVES-1:0]       granted;

    int n_cmp = 0;
    int n_err = 0;

    ahb3lite_interconnect_master_port_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) mif ();

    // single-master bus: the master's HREADY is this port's HREADYOUT
    assign mif.HREADY = mif.HREADYOUT;

    ahb3lite_interconnect_master_port #(
        .HADDR_SIZE (32),
        .HDATA_SIZE (32),
        .MASTERS    (3),
        .SLAVES     (SLAVES)
    ) dut (
        .HRESETn      (HRESETn),
        .HCLK         (HCLK),
        .mst_priority (mst_priority),
        .slvHADDRbase (slvHADDRbase),
        .slvHADDRmask (slvHADDRmask),
        .mst          (mif),
        .slvHSEL      (slvHSEL),
        .slvHADDR     (slvHADDR),
        .slvHWDATA    (slvHWDATA),
        .slvHWRITE    (slvHWRITE),
        .slvHSIZE     (slvHSIZE),
        .slvHBURST    (slvHBURST),
        .slvHPROT     (slvHPROT),
        .slvHTRANS    (slvHTRANS),
        .slvHMASTLOCK (slvHMASTLOCK),
        .slvHREADY    (slvHREADY),
        .slvpriority  (slvpriority),
        .slvHRDATA    (slvHRDATA),
        .slvHREADYOUT (slvHREADYOUT),
        .slvHRESP     (slvHRESP),
        .can_switch   (can_switch),
        .granted      (granted)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic write, input logic [2:0] burst, input logic lock);
        mif.HSEL      = sel;
        mif.HTRANS    = trans;
        mif.HADDR     = addr;
        mif.HWRITE    = write;
        mif.HBURST    = burst;
        mif.HMASTLOCK = lock;
    endtask

    initial begin
        HRESETn         = 1'b0;
        mst_priority    = 2'd2;
        slvHADDRbase[0] = 32'h0000_0000;
        slvHADDRmask[0] = 32'hF000_0000;
        slvHADDRbase[1] = 32'h1000_0000;
        slvHADDRmask[1] = 32'hF000_0000;
        slvHRDATA[0]    = 32'hAAAA_0000;
        slvHRDATA[1]    = 32'hBBBB_1111;
        slvHREADYOUT    = 2'b11;
        slvHRESP        = 2'b00;
        granted         = 2'b00;
        mif.HWDATA      = 32'h1234_5678;
        mif.HSIZE       = 3'd2;
        mif.HPROT       = 4'h3;
        bus(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);

        tick(); tick();
        $display("reset state");
        chk("rst_hreadyout", 64'(mif.HREADYOUT), 64'h1);
        chk("rst_hresp", 64'(mif.HRESP), 64'h0);
        chk("rst_hrdata", 64'(mif.HRDATA), 64'h0);
        chk("rst_slvhsel", 64'(slvHSEL), 64'h0);
        chk("rst_can_switch", 64'(can_switch), 64'h3);
        chk("priority", 64'(slvpriority), 64'h2);
        chk("hwdata_pass", 64'(slvHWDATA), 64'h1234_5678);
        HRESETn = 1'b1;
        tick();

        $display("granted NONSEQ to 0x10000004");
        bus(1'b1, 2'b10, 32'h1000_0004, 1'b0, 3'd0, 1'b0);
        granted = 2'b10;
        #1;
        chk("pass_slvhsel", 64'(slvHSEL), 64'h2);
        chk("pass_slvhaddr", 64'(slvHADDR), 64'h1000_0004);
        chk("pass_slvhtrans", 64'(slvHTRANS), 64'h2);
        chk("pass_slvhready", 64'(slvHREADY), 64'h1);
        tick();
        bus(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        #1;
        chk("pass_hrdata", 64'(mif.HRDATA), 64'hBBBB_1111);
        chk("pass_hresp", 64'(mif.HRESP), 64'h0);
        chk("pass_hreadyout", 64'(mif.HREADYOUT), 64'h1);
        tick();

        $display("ungranted NONSEQ to 0x00000010 held for 3 cycles");
        bus(1'b1, 2'b10, 32'h0000_0010, 1'b1, 3'd0, 1'b0);
        granted = 2'b00;
        #1;
        chk("wait_req_slvhsel", 64'(slvHSEL), 64'h1);
        tick();
        bus(1'b1, 2'b10, 32'h1000_0000, 1'b0, 3'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("wait_hreadyout", 64'(mif.HREADYOUT), 64'h0);
            chk("wait_slvhaddr", 64'(slvHADDR), 64'h0000_0010);
            chk("wait_slvhwrite", 64'(slvHWRITE), 64'h1);
            chk("wait_slvhsel", 64'(slvHSEL), 64'h1);
            chk("wait_slvhready", 64'(slvHREADY), 64'h0);
            if (c < 2) tick();
        end
        granted = 2'b01;
        tick();
        bus(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        #1;
        chk("release_hreadyout", 64'(mif.HREADYOUT), 64'h1);
        chk("release_hrdata", 64'(mif.HRDATA), 64'hAAAA_0000);
        tick();

        $display("ungranted SEQ to 0x10000008");
        bus(1'b1, 2'b11, 32'h1000_0008, 1'b0, 3'd1, 1'b0);
        granted = 2'b00;
        tick();
        chk("seq_held_slvhtrans", 64'(slvHTRANS), 64'h2);
        chk("seq_held_slvhsel", 64'(slvHSEL), 64'h2);
        chk("seq_held_hreadyout", 64'(mif.HREADYOUT), 64'h0);
        granted = 2'b10;
        tick();
        bus(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        #1;
        chk("seq_release_hrdata", 64'(mif.HRDATA), 64'hBBBB_1111);
        tick();

        $display("unmapped NONSEQ to 0x20000000");
        bus(1'b1, 2'b10, 32'h2000_0000, 1'b0, 3'd0, 1'b0);
        #1;
        chk("err_slvhsel", 64'(slvHSEL), 64'h0);
        tick();
        bus(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        #1;
        chk("err1_rdy_resp", 64'({mif.HREADYOUT, mif.HRESP}), 64'h1);
        tick();
        chk("err2_rdy_resp", 64'({mif.HREADYOUT, mif.HRESP}), 64'h3);
        tick();
        chk("err_done_rdy_resp", 64'({mif.HREADYOUT, mif.HRESP}), 64'h2);

        $display("INCR4 unlocked to slave 1");
        granted = 2'b10;
        bus(1'b1, 2'b10, 32'h1000_0000, 1'b0, 3'd3, 1'b0);
        tick();
        for (int b = 1; b <= 3; b++) begin
            bus(1'b1, 2'b11, 32'h1000_0000 + 32'(4 * b), 1'b0, 3'd3, 1'b0);
            #1;
            chk("incr4_cs1_mid", 64'(can_switch[1]), 64'h0);
            tick();
        end
        bus(1'b1, 2'b00, 32'h1000_000C, 1'b0, 3'd3, 1'b0);
        #1;
        chk("incr4_cs1_end", 64'(can_switch[1]), 64'h1);
        tick();

        $display("INCR4 locked to slave 1");
        bus(1'b1, 2'b10, 32'h1000_0000, 1'b0, 3'd3, 1'b1);
        #1;
        chk("lock_cs1_first", 64'(can_switch[1]), 64'h0);
        chk("lock_cs0_free", 64'(can_switch[0]), 64'h1);
        tick();
        for (int b = 1; b <= 3; b++) begin
            bus(1'b1, 2'b11, 32'h1000_0000 + 32'(4 * b), 1'b0, 3'd3, 1'b1);
            #1;
            chk("lock_cs1_mid", 64'(can_switch[1]), 64'h0);
            tick();
        end
        bus(1'b1, 2'b00, 32'h1000_000C, 1'b0, 3'd3, 1'b1);
        #1;
        chk("lock_cs1_end", 64'(can_switch[1]), 64'h0);
        tick();
        bus(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        tick();

        $display("reset during WAIT");
        granted = 2'b00;
        bus(1'b1, 2'b10, 32'h0000_0020, 1'b0, 3'd0, 1'b0);
        tick();
        chk("rwait_hreadyout", 64'(mif.HREADYOUT), 64'h0);
        HRESETn = 1'b0;
        bus(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0);
        tick();
        chk("rwait_after_hreadyout", 64'(mif.HREADYOUT), 64'h1);
        chk("rwait_after_slvhsel", 64'(slvHSEL), 64'h0);
        chk("rwait_after_hresp", 64'(mif.HRESP), 64'h0);
        chk("rwait_after_slvhready", 64'(slvHREADY), 64'h1);
        HRESETn = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
